uart_tx_param: RTL

Parametrised successor to the fixed 8N1 UART transmitter. Serialises DATA_BITS-wide words with optional parity and one or two stop bits, at a baud rate derived from CLK_FREQ/BAUD. It uses a valid/ready handshake in place of a bare enable, and adds a busy flag and a done pulse. It sits between the system-side byte producer and the TX pin.

---
 rtl/uart_tx_param.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: DATA_BITS data bits, optional parity, 1 or 2 stop bits, valid/ready input.
// Define TX_FIFO_EN to place a FIFO_DEPTH-entry buffer in front of the FSM, which allows back-to-back frames.
module uart_tx_param #(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 en_i,
   input  logic [DATA_BITS-1:0] data_i,
   output logic                 ready_o,
   output logic                 tx_o,
   output logic                 busy_o,
   output logic                 tx_done_o
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int IDX_W        = $clog2(DATA_BITS);

   if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
       STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
      $error("uart_tx_param: illegal parameter set");
   end

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t               state, state_nxt;
   logic [CNT_W-1:0]     baud_cnt, baud_cnt_nxt;
   logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_q;
   logic                 bit_end;
   logic                 load;
   logic                 shift_en;
   logic                 word_avail;
   logic [DATA_BITS-1:0] load_word;

   function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
      return (PARITY == 1) ? ~(^w) : ^w;
   endfunction

`ifdef TX_FIFO_EN
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam bit CHAIN = 1'b1;

   logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
   logic [AW:0]          wr_ptr, rd_ptr;
   logic                 fifo_full, fifo_empty, push;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]});
   assign ready_o    = !fifo_full;
   assign push       = en_i && !fifo_full;
   assign word_avail = !fifo_empty;
   assign load_word  = fifo_mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (load) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr[AW-1:0]] <= data_i;
   end
`else
   localparam bit CHAIN = 1'b0;

   assign ready_o    = (state == S_IDLE);
   assign word_avail = en_i;
   assign load_word  = data_i;
`endif

   assign bit_end = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign busy_o  = (state != S_IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
      end else begin
         state    <= state_nxt;
         baud_cnt <= baud_cnt_nxt;
         bit_idx  <= bit_idx_nxt;
      end
   end

   // Shift register and parity hold payload only, so they carry no reset.
   always_ff @(posedge clk) begin
      if (load) begin
         shift_q <= load_word;
         par_q   <= parity_of(load_word);
      end else if (shift_en) begin
         shift_q <= shift_q >> 1;
      end
   end

   always_comb begin
      state_nxt    = state;
      baud_cnt_nxt = baud_cnt + 1'b1;
      bit_idx_nxt  = bit_idx;
      load         = 1'b0;
      shift_en     = 1'b0;
      tx_done_o    = 1'b0;
      case (state)
         S_IDLE: begin
            baud_cnt_nxt = '0;
            if (word_avail) begin
               load      = 1'b1;
               state_nxt = S_START;
            end
         end
         S_START: begin
            if (bit_end) begin
               baud_cnt_nxt = '0;
               state_nxt    = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_end) begin
               baud_cnt_nxt = '0;
               shift_en     = 1'b1;
               if (bit_idx == IDX_W'(DATA_BITS - 1)) begin
                  bit_idx_nxt = '0;
                  state_nxt   = (PARITY != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_idx_nxt = bit_idx + 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               baud_cnt_nxt = '0;
               state_nxt    = S_STOP;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               baud_cnt_nxt = '0;
               if (bit_idx == IDX_W'(STOP_BITS - 1)) begin
                  bit_idx_nxt = '0;
                  tx_done_o   = 1'b1;
                  // With a buffer behind us the next frame starts with no idle cycle.
                  if (CHAIN && word_avail) begin
                     load      = 1'b1;
                     state_nxt = S_START;
                  end else begin
                     state_nxt = S_IDLE;
                  end
               end else begin
                  bit_idx_nxt = bit_idx + 1'b1;
               end
            end
         end
         default: begin
            state_nxt    = S_IDLE;
            baud_cnt_nxt = '0;
            bit_idx_nxt  = '0;
         end
      endcase
   end

   always_comb begin
      case (state)
         S_START:  tx_o = 1'b0;
         S_DATA:   tx_o = shift_q[0];
         S_PARITY: tx_o = par_q;
         default:  tx_o = 1'b1;
      endcase
   end

endmodule
